// File: rtl/poll_result_unit.sv
// Result stage of the voting machine: counts votes while the poll is open, then on close
// snapshots the tallies, decides the winner/tie, audits the total and streams a 5-byte frame.
module poll_result_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vote_done,
  input  logic       close_poll,
  input  logic [3:0] vote_count0,
  input  logic [3:0] vote_count1,
  input  logic [3:0] vote_count2,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [1:0] winner,
  output logic       tie,
  output logic [5:0] total,
  output logic       audit_err,
  output logic       result_valid
);

  typedef enum logic [2:0] {
    COLLECT,
    CMP1,
    CMP2,
    SEND,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic       vd_q, vd_d;
  logic [5:0] ev_cnt_q, ev_cnt_d;
  logic [3:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic       best_idx_q, best_idx_d;
  logic [3:0] best_val_q, best_val_d;
  logic       tie1_q, tie1_d;
  logic [1:0] winner_q, winner_d;
  logic       tie_q, tie_d;
  logic [5:0] total_q, total_d;
  logic       audit_err_q, audit_err_d;
  logic [2:0] idx_q, idx_d;
  logic [5:0] sum;

  // Widened before adding so the worst case 15+15+15 = 45 cannot wrap.
  assign sum = {2'b00, s0_q} + {2'b00, s1_q} + {2'b00, s2_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      vd_q        <= 1'b0;
      ev_cnt_q    <= 6'd0;
      s0_q        <= 4'd0;
      s1_q        <= 4'd0;
      s2_q        <= 4'd0;
      best_idx_q  <= 1'b0;
      best_val_q  <= 4'd0;
      tie1_q      <= 1'b0;
      winner_q    <= 2'd0;
      tie_q       <= 1'b0;
      total_q     <= 6'd0;
      audit_err_q <= 1'b0;
      idx_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      vd_q        <= vd_d;
      ev_cnt_q    <= ev_cnt_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      tie1_q      <= tie1_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
      total_q     <= total_d;
      audit_err_q <= audit_err_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vd_d         = vd_q;
    ev_cnt_d     = ev_cnt_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    best_idx_d   = best_idx_q;
    best_val_d   = best_val_q;
    tie1_d       = tie1_q;
    winner_d     = winner_q;
    tie_d        = tie_q;
    total_d      = total_q;
    audit_err_d  = audit_err_q;
    idx_d        = idx_q;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    result_valid = 1'b0;

    case (state_q)
      COLLECT: begin
        vd_d = vote_done;
        if (vote_done && !vd_q && (ev_cnt_q != 6'd63)) begin
          ev_cnt_d = ev_cnt_q + 6'd1;
        end
        if (close_poll) begin
          s0_d    = vote_count0;
          s1_d    = vote_count1;
          s2_d    = vote_count2;
          state_d = CMP1;
        end
      end
      CMP1: begin
        best_idx_d = (s1_q > s0_q);
        best_val_d = (s1_q > s0_q) ? s1_q : s0_q;
        tie1_d     = (s0_q == s1_q);
        state_d    = CMP2;
      end
      CMP2: begin
        // Strict compare keeps the lowest index when candidate 2 only equals the leader.
        if (s2_q > best_val_q) begin
          winner_d = 2'd2;
          tie_d    = 1'b0;
        end else if (s2_q == best_val_q) begin
          winner_d = {1'b0, best_idx_q};
          tie_d    = 1'b1;
        end else begin
          winner_d = {1'b0, best_idx_q};
          tie_d    = tie1_q;
        end
        total_d     = sum;
        audit_err_d = (sum != ev_cnt_q);
        idx_d       = 3'd0;
        state_d     = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        case (idx_q)
          3'd0:    tx_data = {4'h0, s0_q};
          3'd1:    tx_data = {4'h0, s1_q};
          3'd2:    tx_data = {4'h0, s2_q};
          3'd3:    tx_data = {tie_q, audit_err_q, total_q};
          default: tx_data = {6'h00, winner_q};
        endcase
        if (tx_ready) begin
          if (idx_q == 3'd4) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DONE: begin
        result_valid = 1'b1;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign winner    = winner_q;
  assign tie       = tie_q;
  assign total     = total_q;
  assign audit_err = audit_err_q;

endmodule

// File: tb/tb_poll_result_unit.sv
// Directed bench for poll_result_unit: frame bytes are scoreboarded in a queue filled from an
// independent winner/tie/audit model and drained on every accepted transfer.
module tb_poll_result_unit;

  logic       clk;
  logic       rst_n;
  logic       vote_done;
  logic       close_poll;
  logic [3:0] vc0, vc1, vc2;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] winner;
  logic       tie;
  logic [5:0] total;
  logic       audit_err;
  logic       result_valid;

  int         checks = 0;
  int         failures = 0;
  int         acc_cnt = 0;
  logic [7:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] held = 8'h00;

  poll_result_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vote_done    (vote_done),
    .close_poll   (close_poll),
    .vote_count0  (vc0),
    .vote_count1  (vc1),
    .vote_count2  (vc2),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .winner       (winner),
    .tie          (tie),
    .total        (total),
    .audit_err    (audit_err),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%02h want=%02h", tag, got, exp);
    end
  endtask

  // Sampled on the falling edge: pops the scoreboard on each accepted byte and checks stall hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && tx_valid) checkOutput("stall_hold", tx_data, held);
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("[TB] FAIL extra_byte got=%02h want=none", tx_data);
        end else begin
          checkOutput("frame_byte", tx_data, exp_q.pop_front());
        end
      end
      hold_pending = tx_valid && !tx_ready;
      held         = tx_data;
    end
  end

  task automatic doReset();
    rst_n      = 1'b0;
    vote_done  = 1'b0;
    close_poll = 1'b0;
    tx_ready   = 1'b0;
    vc0 = 4'd0; vc1 = 4'd0; vc2 = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    acc_cnt = 0;
  endtask

  task automatic pulseVotes(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 vote_done = 1'b1;
      @(posedge clk); #1 vote_done = 1'b0;
    end
  endtask

  // Full poll: optional reset, votes, close, then run the frame out and check results/latency.
  task automatic applyStimulus(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                               input int pulses, input bit rnd, input bit skip_reset,
                               input int stop_after);
    logic [3:0] mx;
    logic [1:0] ew;
    logic       et;
    logic [5:0] etot;
    logic       eaud;
    int         k, first_v, first_r;
    if (!skip_reset) doReset();
    vc0 = c0; vc1 = c1; vc2 = c2;
    pulseVotes(pulses);
    mx   = (c0 >= c1) ? c0 : c1;
    mx   = (c2 > mx) ? c2 : mx;
    ew   = (c0 == mx) ? 2'd0 : ((c1 == mx) ? 2'd1 : 2'd2);
    et   = ((c0 == mx) + (c1 == mx) + (c2 == mx)) >= 2;
    etot = 6'(c0) + 6'(c1) + 6'(c2);
    eaud = (etot != 6'(pulses));
    exp_q.push_back({4'h0, c0});
    exp_q.push_back({4'h0, c1});
    exp_q.push_back({4'h0, c2});
    exp_q.push_back({et, eaud, etot});
    exp_q.push_back({6'h00, ew});
    @(posedge clk); #1 close_poll = 1'b1;
    tx_ready = rnd ? 1'b0 : 1'b1;
    @(posedge clk);
    #1 close_poll = 1'b0;
    vc0 = 4'($urandom_range(0, 15));
    vc1 = 4'($urandom_range(0, 15));
    vc2 = 4'($urandom_range(0, 15));
    k = 0; first_v = -1; first_r = -1;
    while (first_r < 0 && k < 300) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      @(posedge clk); k++; #1;
      if (k == 2 && stop_after < 0) begin
        checkOutput("winner_cmp2", 8'(winner), 8'(ew));
        checkOutput("tie_cmp2", 8'(tie), 8'(et));
        checkOutput("total_cmp2", 8'(total), 8'(etot));
        checkOutput("audit_cmp2", 8'(audit_err), 8'(eaud));
      end
      if (tx_valid && first_v < 0) first_v = k;
      if (result_valid) first_r = k;
      if (stop_after >= 0 && acc_cnt == stop_after) break;
    end
    if (stop_after >= 0) begin
      checkOutput("mid_frame_accepts", 8'(acc_cnt), 8'(stop_after));
      return;
    end
    checkOutput("result_valid", 8'(result_valid), 8'd1);
    if (!rnd) begin
      checkOutput("tx_valid_latency", 8'(first_v), 8'd2);
      checkOutput("result_latency", 8'(first_r), 8'd7);
    end
    checkOutput("accepted_count", 8'(acc_cnt), 8'd5);
    checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);
    checkOutput("tx_valid_done", 8'(tx_valid), 8'd0);
    checkOutput("winner_hold", 8'(winner), 8'(ew));
    checkOutput("tie_hold", 8'(tie), 8'(et));
    checkOutput("audit_hold", 8'(audit_err), 8'(eaud));
  endtask

  initial begin
    rst_n      = 1'b0;
    vote_done  = 1'b0;
    close_poll = 1'b0;
    tx_ready   = 1'b0;
    vc0 = 4'd0; vc1 = 4'd0; vc2 = 4'd0;
    #1;
    checkOutput("reset_tx_valid", 8'(tx_valid), 8'd0);
    checkOutput("reset_tx_data", tx_data, 8'h00);
    checkOutput("reset_winner", 8'(winner), 8'd0);
    checkOutput("reset_total", 8'(total), 8'd0);
    checkOutput("reset_result_valid", 8'(result_valid), 8'd0);

    applyStimulus(4'd3, 4'd1, 4'd2, 6,  1'b0, 1'b0, -1);
    applyStimulus(4'd2, 4'd5, 4'd5, 12, 1'b0, 1'b0, -1);
    applyStimulus(4'd4, 4'd4, 4'd1, 8,  1'b0, 1'b0, -1);
    applyStimulus(4'd0, 4'd0, 4'd0, 0,  1'b0, 1'b0, -1);
    applyStimulus(4'd7, 4'd9, 4'd3, 19, 1'b1, 1'b0, -1);
    applyStimulus(4'd15, 4'd15, 4'd15, 45, 1'b1, 1'b0, -1);

    // Reset asserted after b2 has been accepted, then a fresh poll without another reset.
    applyStimulus(4'd3, 4'd1, 4'd2, 6, 1'b0, 1'b0, 3);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_tx_valid", 8'(tx_valid), 8'd0);
    checkOutput("midrst_tx_data", tx_data, 8'h00);
    checkOutput("midrst_winner", 8'(winner), 8'd0);
    checkOutput("midrst_tie", 8'(tie), 8'd0);
    checkOutput("midrst_total", 8'(total), 8'd0);
    checkOutput("midrst_audit", 8'(audit_err), 8'd0);
    checkOutput("midrst_result_valid", 8'(result_valid), 8'd0);
    exp_q.delete();
    tx_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    acc_cnt = 0;
    applyStimulus(4'd1, 4'd2, 4'd0, 3, 1'b0, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
